// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: shift function codes and the ID/EX control bundle.
// Used by decode, ID/EX and EX so the field layout stays in one place.
package pipe_pkg;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SLLV = 6'h04;

  typedef struct packed {
    logic alusrc;
    logic regwrite;
    logic memread;
    logic memwrite;
    logic memtoreg;
  } ctrl_t;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: MEM result beats WB result beats registered data.
// Purely combinational, no backpressure; register 0 is never forwarded.
module fwd_mux #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [DATA_W-1:0] reg_data,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] data
);

  logic mem_hit;
  logic wb_hit;

  assign mem_hit = mem_regwrite && (mem_rd != '0) && (mem_rd == src);
  assign wb_hit  = wb_regwrite  && (wb_rd  != '0) && (wb_rd  == src);

  always_comb begin
    data = reg_data;
    if (mem_hit)     data = mem_result;
    else if (wb_hit) data = wb_result;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with EX forwarding, load-use hazard detection and shifter operand drive.
// One edge ID->EX latency; stall_i holds (operands refresh from forwarding), flush_i/hazard insert bubbles.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int SHAMT_W = 5,
  parameter int FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               id_valid,
  input  logic [REG_AW-1:0]  id_rs,
  input  logic [REG_AW-1:0]  id_rt,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [DATA_W-1:0]  id_rs_data,
  input  logic [DATA_W-1:0]  id_rt_data,
  input  logic [DATA_W-1:0]  id_imm,
  input  logic [SHAMT_W-1:0] id_shamt,
  input  logic [FUNCT_W-1:0] id_funct,
  input  logic               id_alusrc,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic               id_memtoreg,
  input  logic               mem_regwrite,
  input  logic [REG_AW-1:0]  mem_rd,
  input  logic [DATA_W-1:0]  mem_result,
  input  logic               wb_regwrite,
  input  logic [REG_AW-1:0]  wb_rd,
  input  logic [DATA_W-1:0]  wb_result,
  output logic               hazard_o,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_dataA,
  output logic [DATA_W-1:0]  ex_dataB,
  output logic [DATA_W-1:0]  ex_store_data,
  output logic [DATA_W-1:0]  ex_shift_src,
  output logic [SHAMT_W-1:0] ex_shift_amt,
  output logic [FUNCT_W-1:0] ex_funct,
  output logic [REG_AW-1:0]  ex_rd,
  output logic               ex_regwrite,
  output logic               ex_memread,
  output logic               ex_memwrite,
  output logic               ex_memtoreg
);

  logic [REG_AW-1:0]  ex_rs;
  logic [REG_AW-1:0]  ex_rt;
  logic [DATA_W-1:0]  rs_data;
  logic [DATA_W-1:0]  rt_data;
  logic [DATA_W-1:0]  imm;
  logic [SHAMT_W-1:0] shamt;
  ctrl_t              ctrl;
  ctrl_t              id_ctrl;
  logic [DATA_W-1:0]  fwd_a;
  logic [DATA_W-1:0]  fwd_b;

  assign id_ctrl = '{alusrc:   id_alusrc,
                     regwrite: id_regwrite,
                     memread:  id_memread,
                     memwrite: id_memwrite,
                     memtoreg: id_memtoreg};

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
    .src(ex_rs), .reg_data(rs_data),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(fwd_a)
  );

  fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
    .src(ex_rt), .reg_data(rt_data),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .data(fwd_b)
  );

  assign hazard_o = ex_valid && ctrl.memread && (ex_rd != '0) && id_valid &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid <= 1'b0;
      ctrl     <= '0;
      ex_rs    <= '0;
      ex_rt    <= '0;
      ex_rd    <= '0;
      rs_data  <= '0;
      rt_data  <= '0;
      imm      <= '0;
      shamt    <= '0;
      ex_funct <= '0;
    end else if (flush_i) begin
      ex_valid <= 1'b0;
      ctrl     <= '0;
    end else if (stall_i) begin
      // Refresh held operands so a WB result retiring during the stall is not lost.
      rs_data <= fwd_a;
      rt_data <= fwd_b;
    end else if (hazard_o) begin
      ex_valid <= 1'b0;
      ctrl     <= '0;
    end else begin
      ex_valid <= id_valid;
      ctrl     <= id_ctrl;
      ex_rs    <= id_rs;
      ex_rt    <= id_rt;
      ex_rd    <= id_rd;
      rs_data  <= id_rs_data;
      rt_data  <= id_rt_data;
      imm      <= id_imm;
      shamt    <= id_shamt;
      ex_funct <= id_funct;
    end
  end

  assign ex_dataA      = fwd_a;
  assign ex_dataB      = ctrl.alusrc ? imm : fwd_b;
  assign ex_store_data = fwd_b;
  assign ex_shift_src  = fwd_b;
  // Variable shifts take only the low bits of rs, so the amount wraps.
  assign ex_shift_amt  = (ex_funct == FN_SLLV) ? fwd_a[SHAMT_W-1:0] : shamt;
  assign ex_regwrite   = ctrl.regwrite;
  assign ex_memread    = ctrl.memread;
  assign ex_memwrite   = ctrl.memwrite;
  assign ex_memtoreg   = ctrl.memtoreg;

endmodule
